// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// The sequencer has two states, plus register-zero and multiplier latency bounds.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_EXEC = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MUL_LAT_MIN = 2;
  localparam int         MUL_LAT_MAX = 16;
  localparam int         SEQ_CNT_W   = 4;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall-cycle performance count.
// It stops at all-ones and never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count qualifying cycles and hold at the maximum value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage core. It handles load-use stalls,
// taken-branch flushes and multi-cycle MUL occupancy of EX.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_mul,
  input  logic             branch_taken,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             ex_mem_bubble,
  output logic             mul_start,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [SEQ_CNT_W-1:0] CNT_LOAD = SEQ_CNT_W'(MUL_LAT - 1);

  state_e               state_r;
  state_e               next_state_s;
  logic [SEQ_CNT_W-1:0] cnt_r;
  logic [SEQ_CNT_W-1:0] cnt_next_s;
  logic                 load_use_s;

  // A load in EX whose destination feeds the ID instruction forces one bubble.
  assign load_use_s = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // State and MUL down-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
      cnt_r   <= {SEQ_CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic: the load-use hazard blocks MUL entry for that cycle.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      RUN: begin
        if (!load_use_s && id_is_mul) begin
          next_state_s = MUL_EXEC;
          cnt_next_s   = CNT_LOAD;
        end else begin
          next_state_s = RUN;
          cnt_next_s   = cnt_r;
        end
      end
      MUL_EXEC: begin
        cnt_next_s = cnt_r - {{(SEQ_CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r <= {{(SEQ_CNT_W-1){1'b0}}, 1'b1}) begin
          next_state_s = RUN;
        end else begin
          next_state_s = MUL_EXEC;
        end
      end
      default: begin
        next_state_s = RUN;
        cnt_next_s   = {SEQ_CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode: the priority in RUN is load-use, then branch flush.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_bubble = 1'b0;
    mul_start     = 1'b0;
    case (state_r)
      RUN: begin
        if (load_use_s) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
        end else begin
          if_id_flush = 1'b0;
        end
      end
      MUL_EXEC: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_hold    = 1'b1;
        ex_mem_bubble = 1'b1;
        if (cnt_r == CNT_LOAD) begin
          mul_start = 1'b1;
        end else begin
          mul_start = 1'b0;
        end
      end
      default: begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (~pc_write),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl with MUL_LAT=4 and CNT_W=4. Each cycle's
// expected control vector and stall count are queued with the stimulus.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
  logic       id_uses_rt = 1'b0, id_is_mul = 1'b0, branch_taken = 1'b0, ex_mem_read = 1'b0;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start;
  logic [3:0] stall_cnt;

  typedef struct packed {
    logic       mul, br, mr, urt;
    logic [4:0] rs, rt, ert;
  } stim_t;

  typedef struct packed {
    logic [6:0] ctl;
    logic [3:0] cnt;
  } exp_t;

  stim_t stim_q[$];
  exp_t  sb_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Control vector order: pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start
  localparam logic [6:0] C_RUN   = 7'b1100000;
  localparam logic [6:0] C_LOAD  = 7'b0001000;
  localparam logic [6:0] C_FLUSH = 7'b1110000;
  localparam logic [6:0] C_MUL1  = 7'b0000111;
  localparam logic [6:0] C_MULN  = 7'b0000110;
  localparam stim_t      IDLE    = '0;

  hazard_stall_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_mul(id_is_mul), .branch_taken(branch_taken), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble),
    .mul_start(mul_start), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic mul, input logic br, input logic mr, input logic urt,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert);
    stim_t s;
    s = '{mul: mul, br: br, mr: mr, urt: urt, rs: rs, rt: rt, ert: ert};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    id_is_mul = s.mul; branch_taken = s.br; ex_mem_read = s.mr; id_uses_rt = s.urt;
    id_rs = s.rs; id_rt = s.rt; ex_rt = s.ert;
  endtask

  task automatic push(input stim_t s, input logic [6:0] c, input logic [3:0] n);
    stim_q.push_back(s);
    sb_q.push_back('{ctl: c, cnt: n});
  endtask

  task automatic apply_reset();
    drive(IDLE);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(IDLE);
    rst = 1'b0;
    #3;
    vectors++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start} !== C_RUN || stall_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_initial: got ctl=%b cnt=%0d, expected ctl=%b cnt=0",
               {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start}, stall_cnt, C_RUN);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0), C_RUN, 4'd0);
    push(IDLE, C_MUL1, 4'd0);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start} !== e.ctl || stall_cnt !== e.cnt) begin
        miscompares++;
        $display("FAIL reset_pre_mul: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start}, stall_cnt, e.ctl, e.cnt);
      end
      @(posedge clk);
      #1;
    end
    // Now in the MUL_EXEC cycle with cnt=2: reset asynchronously mid-sequence.
    drive(IDLE);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start} !== C_RUN || stall_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_async_mid_mul: got ctl=%b cnt=%0d, expected ctl=%b cnt=0",
               {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start}, stall_cnt, C_RUN);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push(IDLE, C_RUN, 4'd0);
    push(IDLE, C_RUN, 4'd0);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start} !== e.ctl || stall_cnt !== e.cnt) begin
        miscompares++;
        $display("FAIL reset_release: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start}, stall_cnt, e.ctl, e.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    apply_reset();
    push(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 5'd2, 5'd8), C_LOAD, 4'd0);
    push(IDLE, C_RUN, 4'd1);
    push(mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0), C_RUN, 4'd1);
    push(mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd9, 5'd9), C_LOAD, 4'd1);
    push(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd9, 5'd9), C_RUN, 4'd2);
    push(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd9), C_RUN, 4'd2);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start} !== e.ctl || stall_cnt !== e.cnt) begin
        miscompares++;
        $display("FAIL load_use: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start}, stall_cnt, e.ctl, e.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_priority();
    exp_t e;
    apply_reset();
    push(mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 5'd8), C_LOAD, 4'd0);
    push(mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 5'd0, 5'd8), C_FLUSH, 4'd1);
    push(mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd5), C_LOAD, 4'd1);
    push(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd5), C_RUN, 4'd2);
    push(IDLE, C_MUL1, 4'd2);
    push(mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd5), C_MULN, 4'd3);
    push(IDLE, C_MULN, 4'd4);
    push(IDLE, C_RUN, 4'd5);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start} !== e.ctl || stall_cnt !== e.cnt) begin
        miscompares++;
        $display("FAIL priority: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start}, stall_cnt, e.ctl, e.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mul();
    exp_t e;
    apply_reset();
    push(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0), C_RUN, 4'd0);
    push(IDLE, C_MUL1, 4'd0);
    push(IDLE, C_MULN, 4'd1);
    push(mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0), C_MULN, 4'd2);
    push(IDLE, C_RUN, 4'd3);
    push(IDLE, C_RUN, 4'd3);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start} !== e.ctl || stall_cnt !== e.cnt) begin
        miscompares++;
        $display("FAIL mul: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start}, stall_cnt, e.ctl, e.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   stalls;
    stim_t m;
    apply_reset();
    stalls = 0;
    m = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 5'd6, 5'd0);
    for (int i = 0; i < 6; i++) begin
      push(m, C_RUN, 4'((stalls > 15) ? 15 : stalls));
      for (int k = 0; k < 3; k++) begin
        push(m, (k == 0) ? C_MUL1 : C_MULN, 4'((stalls > 15) ? 15 : stalls));
        stalls++;
      end
    end
    push(IDLE, C_RUN, 4'd15);
    push(IDLE, C_RUN, 4'd15);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = sb_q.pop_front();
      vectors++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start} !== e.ctl || stall_cnt !== e.cnt) begin
        miscompares++;
        $display("FAIL back_to_back: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, mul_start}, stall_cnt, e.ctl, e.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_priority();
    test_mul();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
